// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I definitions for the MEM stage: opcode constants, load/store
//   func3 encodings, the memory-access FSM state type and small decode
//   helpers.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  // Major opcodes
  localparam logic [6:0] OP_R   = 7'b0110011;  // register-register ALU
  localparam logic [6:0] OP_I1  = 7'b0000011;  // loads
  localparam logic [6:0] OP_I2  = 7'b0010011;  // register-immediate ALU
  localparam logic [6:0] OP_S   = 7'b0100011;  // stores
  localparam logic [6:0] OP_BR  = 7'b1100011;  // branches
  localparam logic [6:0] OP_J   = 7'b1101111;  // JAL
  localparam logic [6:0] OP_JR  = 7'b1100111;  // JALR
  localparam logic [6:0] OP_U   = 7'b0110111;  // LUI
  localparam logic [6:0] OP_UPC = 7'b0010111;  // AUIPC

  // Load/store width encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Opcodes that produce a register result
  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I1) || (op == OP_I2) || (op == OP_J) ||
           (op == OP_JR) || (op == OP_U) || (op == OP_UPC);
  endfunction

  // Natural-alignment violation for halfword and word accesses
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (((f3 == F3_H) || (f3 == F3_HU)) && a[0]) ||
           ((f3 == F3_W) && (a != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
//------------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for the MEM stage.
//   Store side: replicates store data across byte lanes and builds byte
//   strobes from the access size and low address bits.
//   Load side: selects the addressed byte/halfword of the read word and
//   sign- or zero-extends it.
//   Ports:
//     st_addr/st_func3/st_data  -> st_wdata, st_wstrb   (store alignment)
//     ld_addr/ld_func3/ld_rdata -> ld_data               (load extraction)
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_addr,
  input  logic [2:0]  st_func3,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [1:0]  ld_addr,
  input  logic [2:0]  ld_func3,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b0000;
    case (st_func3)
      F3_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_addr;
      end
      F3_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << {st_addr[1], 1'b0};
      end
      F3_W: begin
        st_wstrb = 4'b1111;
      end
      // Undefined store widths still issue a request, but write nothing
      default: st_wstrb = 4'b0000;
    endcase
  end

  // Halfword selection uses only a[1]; a[0] is ignored by design
  assign byte_sh = ld_rdata >> {ld_addr, 3'b000};
  assign half_sh = ld_rdata >> {ld_addr[1], 4'b0000};

  always_comb begin
    ld_data = ld_rdata;
    case (ld_func3)
      F3_B:    ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld_data = {24'h000000, byte_sh[7:0]};
      F3_H:    ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld_data = {16'h0000, half_sh[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit
//   MEM stage of the pipelined RV32I core. Drives a single-port data memory
//   through a req/ack handshake, aligns store data, extracts and extends load
//   data, and presents a registered writeback bundle. Non-memory
//   instructions pass through with one cycle of latency. While an access is
//   outstanding, stall is held high.
//   Optional feature macro: MISALIGN_CHECK_EN
//     defined   - misaligned LH/LHU/SH/LW/SW issue no request and return a
//                 one-cycle misaligned flag with wb_en=0
//     undefined - misaligned port absent, low address bits ignored
//   Ports:
//     clk, rst (async active-low)
//     EX side : in_valid, result, DataStore, rd, func3, opcode,
//               in_ready, stall
//     Memory  : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
//               mem_rdata, mem_ack
//     WB side : wb_valid, wb_en, wb_rd, wb_data [, misaligned]
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] DataStore,
  input  logic [4:0]        rd,
  input  logic [2:0]        func3,
  input  logic [6:0]        opcode,
  output logic              in_ready,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
`ifdef MISALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  mem_state_e state, state_next;

  logic [1:0]        addr_lo_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] ld_data;
  logic              is_mem;
  logic              mis;
  logic              accept;

  assign is_mem = (opcode == OP_I1) || (opcode == OP_S);
  assign accept = in_valid && (state == ST_IDLE);

`ifdef MISALIGN_CHECK_EN
  assign mis = is_mem && is_misaligned(func3, result[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Store lanes are built from the live EX bundle and latched at accept;
  // load extraction uses the latched address bits against returning data.
  lsu_align u_align (
    .st_addr  (result[1:0]),
    .st_func3 (func3),
    .st_data  (DataStore),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_addr  (addr_lo_q),
    .ld_func3 (func3_q),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_mem && !mis) state_next = ST_WAIT;
      ST_WAIT: if (mem_ack)                  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Derived purely from the state register, so no path from in_valid
  assign stall    = (state == ST_WAIT);
  assign in_ready = !stall;
  assign mem_req  = (state == ST_WAIT);

  // Request bundle and writeback registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_lo_q  <= 2'b00;
      func3_q    <= 3'b000;
      rd_q       <= 5'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= 4'b0000;
      wb_valid   <= 1'b0;
      wb_en      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
`ifdef MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misaligned <= 1'b0;
`endif
      if (accept) begin
        if (is_mem && !mis) begin
          mem_addr  <= {result[DATA_W-1:2], 2'b00};
          addr_lo_q <= result[1:0];
          func3_q   <= func3;
          rd_q      <= rd;
          mem_we    <= (opcode == OP_S);
          mem_wdata <= st_wdata;
          mem_wstrb <= st_wstrb;
        end else begin
          // Pass-through, or a rejected misaligned access
          wb_valid <= 1'b1;
          wb_rd    <= rd;
          wb_data  <= result;
          wb_en    <= (rd != 5'd0) && writes_rd(opcode) && !mis;
`ifdef MISALIGN_CHECK_EN
          misaligned <= mis;
`endif
        end
      end else if ((state == ST_WAIT) && mem_ack) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= ld_data;
        wb_en    <= !mem_we && (rd_q != 5'd0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit. Expected writeback bundles are
//   queued when an instruction is driven and compared when wb_valid fires.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        en;
    logic        chk_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] result = '0;
  logic [31:0] DataStore = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  opcode = '0;
  logic        in_ready, stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .result    (result),
    .DataStore (DataStore),
    .rd        (rd),
    .func3     (func3),
    .opcode    (opcode),
    .in_ready  (in_ready),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_valid  (wb_valid),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
`ifdef MISALIGN_CHECK_EN
    ,
    .misaligned(misaligned)
`endif
  );

  // Present one instruction for a single accept edge; returns at edge+1.
  task automatic drive(input logic [6:0] op, input logic [31:0] res,
                       input logic [31:0] st, input logic [4:0] r,
                       input logic [2:0] f3);
    @(negedge clk);
    opcode = op; result = res; DataStore = st; rd = r; func3 = f3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // One ack pulse sampled at the next rising edge; returns at edge+1.
  task automatic ack_with(input logic [31:0] rdata);
    @(negedge clk);
    mem_rdata = rdata;
    mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ctrl got req=%b we=%b stall=%b rdy=%b want 0 0 0 1", mem_req, mem_we, stall, in_ready);
    end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_mem got addr=%h wdata=%h wstrb=%b want zeros", mem_addr, mem_wdata, mem_wstrb);
    end
    checks++; if (wb_valid !== 1'b0 || wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
      errors++; $display("FAIL reset_wb got v=%b en=%b rd=%0d data=%h want zeros", wb_valid, wb_en, wb_rd, wb_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    sb.push_back('{32'h0000_0100, 5'd3, 1'b1, 1'b1});
    drive(OP_R, 32'h100, 32'h0, 5'd3, 3'b000);
    checks++; if (wb_valid !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL add_timing got wb_valid=%b mem_req=%b want 1 0", wb_valid, mem_req);
    end
    if (wb_valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (wb_data !== e.data || wb_rd !== e.rd || wb_en !== e.en) begin
        errors++; $display("FAIL add_wb got data=%h rd=%0d en=%b want %h %0d %b", wb_data, wb_rd, wb_en, e.data, e.rd, e.en);
      end
    end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0 || wb_data !== 32'h100) begin
      errors++; $display("FAIL add_pulse got wb_valid=%b data=%h want 0 00000100", wb_valid, wb_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [4] = '{OP_I2, OP_BR, OP_U, OP_JR};
    logic [4:0]  rds [4] = '{5'd0, 5'd6, 5'd12, 5'd1};
    logic        ens [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = ops[i]; result = 32'hA000_0000 + i; rd = rds[i]; func3 = 3'b000;
      in_valid = 1'b1;
      sb.push_back('{32'hA000_0000 + i, rds[i], ens[i], 1'b1});
      @(posedge clk); #1;
      checks++; if (wb_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL b2b_valid[%0d] got wb_valid=%b want 1", i, wb_valid);
      end else begin
        e = sb.pop_front();
        checks++; if (wb_data !== e.data || wb_rd !== e.rd || wb_en !== e.en) begin
          errors++; $display("FAIL b2b_wb[%0d] got data=%h rd=%0d en=%b want %h %0d %b", i, wb_data, wb_rd, wb_en, e.data, e.rd, e.en);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_lb();
    int stall_cnt = 0;
    sb.push_back('{32'hFFFF_FF80, 5'd5, 1'b1, 1'b1});
    drive(OP_I1, 32'h203, 32'h0, 5'd5, F3_B);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL lb_req got req=%b we=%b addr=%h want 1 0 00000200", mem_req, mem_we, mem_addr);
    end
    if (stall === 1'b1) stall_cnt++;
    repeat (3) begin
      @(posedge clk); #1;
      if (stall === 1'b1) stall_cnt++;
    end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++; $display("FAIL lb_hold got req=%b addr=%h want 1 00000200", mem_req, mem_addr);
    end
    ack_with(32'h80FF_0000);
    if (stall === 1'b1) stall_cnt++;
    checks++; if (stall_cnt != 4 || stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL lb_stall got cycles=%0d stall=%b req=%b want 4 0 0", stall_cnt, stall, mem_req);
    end
    checks++; if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL lb_valid got wb_valid=%b want 1", wb_valid);
    end else begin
      e = sb.pop_front();
      checks++; if (wb_data !== e.data || wb_rd !== e.rd || wb_en !== e.en) begin
        errors++; $display("FAIL lb_wb got data=%h rd=%0d en=%b want %h %0d %b", wb_data, wb_rd, wb_en, e.data, e.rd, e.en);
      end
    end
  endtask

  task automatic test_sh();
    sb.push_back('{32'h0, 5'd7, 1'b0, 1'b0});
    drive(OP_S, 32'h102, 32'h1234_ABCD, 5'd7, F3_H);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 ||
                  mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin
      errors++; $display("FAIL sh_req got req=%b we=%b addr=%h wstrb=%b wdata=%h want 1 1 00000100 1100 abcdabcd",
                         mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    checks++; if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL sh_early got wb_valid=%b want 0", wb_valid);
    end
    ack_with(32'h0);
    checks++; if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL sh_valid got wb_valid=%b want 1", wb_valid);
    end else begin
      e = sb.pop_front();
      checks++; if (wb_en !== e.en || wb_rd !== e.rd) begin
        errors++; $display("FAIL sh_wb got en=%b rd=%0d want %b %0d", wb_en, wb_rd, e.en, e.rd);
      end
    end
    // SB to lane 1 exercises byte replication and a single strobe
    drive(OP_S, 32'h301, 32'h0000_00A5, 5'd0, F3_B);
    checks++; if (mem_wstrb !== 4'b0010 || mem_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL sb_lane got wstrb=%b wdata=%h want 0010 a5a5a5a5", mem_wstrb, mem_wdata);
    end
    ack_with(32'h0);
  endtask

  task automatic test_lhu();
    logic [4:0] rds [2] = '{5'd9, 5'd0};
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{32'h0000_F00D, rds[i], (rds[i] != 5'd0), 1'b1});
      drive(OP_I1, 32'h102, 32'h0, rds[i], F3_HU);
      ack_with(32'hF00D_0000);
      checks++; if (wb_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL lhu_valid[%0d] got wb_valid=%b want 1", i, wb_valid);
      end else begin
        e = sb.pop_front();
        checks++; if (wb_data !== e.data || wb_rd !== e.rd || wb_en !== e.en) begin
          errors++; $display("FAIL lhu_wb[%0d] got data=%h rd=%0d en=%b want %h %0d %b", i, wb_data, wb_rd, wb_en, e.data, e.rd, e.en);
        end
      end
    end
    // LH sign extension from lane 0
    sb.push_back('{32'hFFFF_8001, 5'd10, 1'b1, 1'b1});
    drive(OP_I1, 32'h400, 32'h0, 5'd10, F3_H);
    ack_with(32'h1234_8001);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (wb_valid !== 1'b1 || wb_data !== e.data || wb_en !== e.en) begin
        errors++; $display("FAIL lh_sext got v=%b data=%h en=%b want 1 %h %b", wb_valid, wb_data, wb_en, e.data, e.en);
      end
    end
  endtask

  task automatic test_lw_misaligned();
`ifdef MISALIGN_CHECK_EN
    sb.push_back('{32'h0, 5'd8, 1'b0, 1'b0});
    drive(OP_I1, 32'h101, 32'h0, 5'd8, F3_W);
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || misaligned !== 1'b1 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL lw_mis got req=%b stall=%b mis=%b v=%b want 0 0 1 1", mem_req, stall, misaligned, wb_valid);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (wb_en !== e.en) begin
        errors++; $display("FAIL lw_mis_en got en=%b want %b", wb_en, e.en);
      end
    end
    @(posedge clk); #1;
    checks++; if (misaligned !== 1'b0) begin
      errors++; $display("FAIL lw_mis_pulse got mis=%b want 0", misaligned);
    end
`else
    sb.push_back('{32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1});
    drive(OP_I1, 32'h101, 32'h0, 5'd8, F3_W);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL lw_addr got req=%b addr=%h want 1 00000100", mem_req, mem_addr);
    end
    ack_with(32'hDEAD_BEEF);
    checks++; if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL lw_valid got wb_valid=%b want 1", wb_valid);
    end else begin
      e = sb.pop_front();
      checks++; if (wb_data !== e.data || wb_en !== e.en) begin
        errors++; $display("FAIL lw_wb got data=%h en=%b want %h %b", wb_data, wb_en, e.data, e.en);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    sb.push_back('{32'h1111_1111, 5'd4, 1'b1, 1'b1});
    drive(OP_I1, 32'h40, 32'h0, 5'd4, F3_W);
    checks++; if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rmw_req got req=%b want 1", mem_req);
    end
    #2 rst = 1'b0;
    sb.delete();  // the access is abandoned, nothing will be written back
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL rmw_async got req=%b stall=%b addr=%h v=%b want 0 0 0 0", mem_req, stall, mem_addr, wb_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    ack_with(32'h1111_1111);
    checks++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || wb_en !== 1'b0) begin
      errors++; $display("FAIL rmw_ack got v=%b req=%b stall=%b en=%b want 0 0 0 0", wb_valid, mem_req, stall, wb_en);
    end
    sb.push_back('{32'h0000_0055, 5'd2, 1'b1, 1'b1});
    drive(OP_R, 32'h55, 32'h0, 5'd2, 3'b000);
    checks++; if (wb_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL rmw_add_valid got wb_valid=%b want 1", wb_valid);
    end else begin
      e = sb.pop_front();
      checks++; if (wb_data !== e.data || wb_rd !== e.rd || wb_en !== e.en) begin
        errors++; $display("FAIL rmw_add_wb got data=%h rd=%0d en=%b want %h %0d %b", wb_data, wb_rd, wb_en, e.data, e.rd, e.en);
      end
    end
    checks++; if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_lb();
    test_sh();
    test_lhu();
    test_lw_misaligned();
    test_reset_mid_wait();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got no summary want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
